// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding and default sizing.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 5;

endpackage

// File: rtl/serial_fa_bit.sv
// Combinational 1-bit full-adder cell; the only arithmetic in the serial datapath.
module serial_fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: WIDTH-cycle LSB-first add with start/busy/done handshake.
// Optional subtract mode via SERIAL_ADD_SUB_EN (adds a 'sub' input).
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_co, accept;
    logic [WIDTH-1:0] acc_shift, b_load;
    logic             c_load;

    serial_fa_bit u_fa (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .ci_i (c_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};

    // Subtract is a + ~b + 1: invert B on load and force the initial carry.
`ifdef SERIAL_ADD_SUB_EN
    assign b_load = sub ? ~b : b;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b;
    assign c_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        c_d     = c_q;
        cout_d  = cout_q;
        accept  = 1'b0;

        case (state_q)
            ST_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                acc_d  = acc_shift;
                c_d    = fa_co;
                idx_d  = idx_q + CNT_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    sum_d   = acc_shift;
                    cout_d  = fa_co;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                accept  = start;
            end
            default: begin
                state_d = ST_IDLE;
                accept  = start;
            end
        endcase

        if (accept) begin
            state_d = ST_RUN;
            a_sr_d  = a;
            b_sr_d  = b_load;
            c_d     = c_load;
            idx_d   = '0;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
